uart_tx_core: RTL and testbench

Synthesizable UART transmitter. Serialises bytes from a valid/ready byte interface onto the tx line as 8 data bits, optional parity, and 1 or 2 stop bits. Frame start is gated by the peer's cts_n. It is the DUT-side transmit path whose tx output the UART UVC monitor samples at bit centre.

---
 rtl/uart_tx_core.sv | 153 +++++++++++++++
 tb/tb_uart_tx_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter core: byte valid/ready in, 8 data bits, optional parity
// and one or two stop bits out on tx. A new frame starts only while the
// synchronised cts_n is low.
module uart_tx_core #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int DIVISOR     = CLK_FREQ_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop2,
  input  logic       cts_n,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int            CW       = $clog2(DIVISOR);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state_r;
  logic [CW-1:0] baud_cnt_r;
  logic [2:0]    bit_idx_r;
  logic          stop_idx_r;
  logic [7:0]    data_r;
  logic          par_en_r;
  logic          par_odd_r;
  logic          stop2_r;
  logic          tx_r;
  logic          busy_r;
  logic          frame_done_r;
  logic          cts_meta_r;
  logic          cts_sync_r;
  logic          tx_ready_s;
  logic          bit_end_s;

  // Parity bit: XOR of the data, inverted for odd parity.
  function automatic logic parity_f(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // Two-flop synchroniser for cts_n; resets to "not clear" so no frame can
  // start until the peer has been seen low for two clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cts_meta_r <= 1'b1;
      cts_sync_r <= 1'b1;
    end else begin
      cts_meta_r <= cts_n;
      cts_sync_r <= cts_meta_r;
    end
  end

  assign tx_ready_s = (state_r == IDLE) && (cts_sync_r == 1'b0);
  assign bit_end_s  = (baud_cnt_r == BIT_LAST);

  // Frame sequencer: accepts a byte in IDLE, then walks start, data, optional
  // parity and stop bits, moving tx only when a bit period expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      baud_cnt_r   <= CNT_ZERO;
      bit_idx_r    <= 3'd0;
      stop_idx_r   <= 1'b0;
      data_r       <= 8'h00;
      par_en_r     <= 1'b0;
      par_odd_r    <= 1'b0;
      stop2_r      <= 1'b0;
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (state_r == IDLE) begin
        baud_cnt_r <= CNT_ZERO;
        if (tx_valid && tx_ready_s) begin
          data_r    <= tx_data;
          par_en_r  <= parity_en;
          par_odd_r <= parity_odd;
          stop2_r   <= stop2;
          state_r   <= START;
          tx_r      <= 1'b0;
          busy_r    <= 1'b1;
        end
      end else if (!bit_end_s) begin
        baud_cnt_r <= baud_cnt_r + CNT_ONE;
      end else begin
        baud_cnt_r <= CNT_ZERO;
        case (state_r)
          START: begin
            state_r   <= DATA;
            bit_idx_r <= 3'd0;
            tx_r      <= data_r[0];
          end
          DATA: begin
            if (bit_idx_r == 3'd7) begin
              if (par_en_r) begin
                state_r <= PARITY;
                tx_r    <= parity_f(data_r, par_odd_r);
              end else begin
                state_r    <= STOP;
                stop_idx_r <= 1'b0;
                tx_r       <= 1'b1;
              end
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= data_r[bit_idx_r + 3'd1];
            end
          end
          PARITY: begin
            state_r    <= STOP;
            stop_idx_r <= 1'b0;
            tx_r       <= 1'b1;
          end
          STOP: begin
            if (stop2_r && (stop_idx_r == 1'b0)) begin
              stop_idx_r <= 1'b1;
            end else begin
              state_r      <= IDLE;
              busy_r       <= 1'b0;
              frame_done_r <= 1'b1;
              tx_r         <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            tx_r    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx_ready   = tx_ready_s;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: directed scenarios plus random
// frames, each compared against a bit-level frame model built from the
// line-format rules.
module tb_uart_tx_core;

  localparam int D = 434;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       parity_en;
  logic       parity_odd;
  logic       stop2;
  logic       cts_n;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_core #(.CLK_FREQ_HZ(50000000), .BAUD(115200)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .parity_en(parity_en), .parity_odd(parity_odd),
    .stop2(stop2), .cts_n(cts_n), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  // Count every frame_done pulse seen on the line.
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #(2000000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [7:0] d, input logic pe, input logic po, input logic s2);
    tx_data    = d;
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
    tx_valid   = 1'b1;
  endtask

  // Called at a negedge with the byte already presented. Waits for tx_ready,
  // then checks every bit level (first, centre and last cycle of each bit)
  // and the frame_done timing against the model.
  task automatic check_frame(input logic [7:0] d, input logic pe, input logic po,
                             input logic s2, input int budget,
                             input logic nxt_en, input logic [7:0] nxt_d,
                             input logic nxt_pe, input logic nxt_po, input logic nxt_s2,
                             input int cts_j, output int waited);
    logic lvl[$];
    int   ones;
    int   len;
    waited = 0;
    while (tx_ready !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      check_eq($sformatf("accept_timeout_%02h", d), 32'd0, 32'd1);
      return;
    end
    ones = 0;
    lvl.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      lvl.push_back(((d >> i) & 8'h01) != 8'h00);
      if (((d >> i) & 8'h01) != 8'h00) ones++;
    end
    if (pe) lvl.push_back(((ones % 2) == 1) ^ po);
    lvl.push_back(1'b1);
    if (s2) lvl.push_back(1'b1);
    len = lvl.size() * D;
    @(posedge clk);
    for (int j = 0; j <= len; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check_eq("busy_after_accept", busy, 1);
        check_eq("ready_after_accept", tx_ready, 0);
        if (nxt_en) begin
          present(nxt_d, nxt_pe, nxt_po, nxt_s2);
        end else begin
          tx_data    = ~d;
          parity_en  = ~pe;
          parity_odd = ~po;
          stop2      = ~s2;
          tx_valid   = 1'b0;
        end
      end
      if (j == cts_j) cts_n = 1'b1;
      if (j < len && ((j % D) == 0 || (j % D) == D / 2 || (j % D) == D - 1))
        check_eq($sformatf("tx_%02h_bit%0d_off%0d", d, j / D, j % D), tx, lvl[j / D]);
      if (j == len - 1) check_eq($sformatf("done_early_%02h", d), frame_done, 0);
      if (j == len) begin
        check_eq($sformatf("frame_done_%02h_len%0d", d, len), frame_done, 1);
        check_eq("busy_at_end", busy, 0);
        check_eq("tx_idle_at_end", tx, 1);
      end
    end
  endtask

  initial begin
    int w;
    int done0;
    int rdy_hi;
    int tx_lo;
    int busy_hi;
    logic [7:0] rd;
    logic rpe, rpo, rs2;

    rst = 1'b1;
    cts_n = 1'b0;
    present(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_ready", tx_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_1clk_after_rst", tx_ready, 0);

    // 0x55, no parity, one stop bit: 4340-clock frame.
    check_frame(8'h55, 1'b0, 1'b0, 1'b0, 5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1, w);
    check_eq("ready_latency_after_rst", (w >= 1 && w <= 2), 1);

    // Even then odd parity on 0xA5 (four ones).
    @(negedge clk);
    present(8'hA5, 1'b1, 1'b0, 1'b0);
    check_frame(8'hA5, 1'b1, 1'b0, 1'b0, 5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1, w);
    @(negedge clk);
    present(8'hA5, 1'b1, 1'b1, 1'b0);
    check_frame(8'hA5, 1'b1, 1'b1, 1'b0, 5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1, w);

    // Two stop bits, with the next byte waiting: no idle gap between frames.
    @(negedge clk);
    present(8'h0F, 1'b0, 1'b0, 1'b1);
    check_frame(8'h0F, 1'b0, 1'b0, 1'b1, 5, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, -1, w);
    check_frame(8'h96, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1, w);
    check_eq("back_to_back_wait", w, 0);

    // Peer not clear: byte held for 1000 clocks, then exactly one frame.
    @(negedge clk);
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    present(8'h3C, 1'b0, 1'b0, 1'b0);
    done0 = done_cnt;
    rdy_hi = 0; tx_lo = 0; busy_hi = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_ready !== 1'b0) rdy_hi++;
      if (tx !== 1'b1) tx_lo++;
      if (busy !== 1'b0) busy_hi++;
    end
    check_eq("cts_hold_ready_cycles", rdy_hi, 0);
    check_eq("cts_hold_tx_low_cycles", tx_lo, 0);
    check_eq("cts_hold_busy_cycles", busy_hi, 0);
    cts_n = 1'b0;
    check_frame(8'h3C, 1'b0, 1'b0, 1'b0, 10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1, w);
    check_eq("cts_release_latency", (w >= 1 && w <= 3), 1);
    repeat (500) @(negedge clk);
    check_eq("cts_single_frame", done_cnt - done0, 1);
    check_eq("cts_idle_after", busy, 0);

    // cts_n raised mid data: frame completes, next byte waits for cts_n low.
    present(8'h81, 1'b0, 1'b0, 1'b0);
    check_frame(8'h81, 1'b0, 1'b0, 1'b0, 5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5 * D, w);
    present(8'h44, 1'b1, 1'b1, 1'b0);
    rdy_hi = 0; busy_hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready !== 1'b0) rdy_hi++;
      if (busy !== 1'b0) busy_hi++;
    end
    check_eq("cts_mid_next_ready_cycles", rdy_hi, 0);
    check_eq("cts_mid_next_busy_cycles", busy_hi, 0);
    cts_n = 1'b0;
    check_frame(8'h44, 1'b1, 1'b1, 1'b0, 10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1, w);

    // Reset during data bit 3 of 0xC3 (bit 3 is 0).
    @(negedge clk);
    present(8'hC3, 1'b0, 1'b0, 1'b0);
    w = 0;
    while (tx_ready !== 1'b1 && w < 5) begin @(negedge clk); w++; end
    check_eq("c3_ready", tx_ready, 1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (4 * D + 100) @(negedge clk);
    check_eq("c3_bit3_before_rst", tx, 0);
    done0 = done_cnt;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_tx", tx, 1);
    check_eq("rst_mid_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (D) @(negedge clk);
    check_eq("rst_mid_no_done", done_cnt - done0, 0);
    check_eq("rst_mid_idle_tx", tx, 1);
    present(8'h12, 1'b0, 1'b0, 1'b0);
    check_frame(8'h12, 1'b0, 1'b0, 1'b0, 5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1, w);

    // Random frames with random gaps.
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(20, 0)) @(negedge clk);
      rd  = 8'($urandom_range(255, 0));
      rpe = 1'($urandom_range(1, 0));
      rpo = 1'($urandom_range(1, 0));
      rs2 = 1'($urandom_range(1, 0));
      present(rd, rpe, rpo, rs2);
      check_frame(rd, rpe, rpo, rs2, 5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
